vector_exec_unit: RTL and testbench

//   Multi-cycle, parametrised successor of the single-cycle vector path: owns a NVREG x VLEN

---
 rtl/vector_pkg.sv | 23 ++
 rtl/vector_exec_unit_lane.sv | 56 +++++
 rtl/vector_exec_unit.sv | 158 +++++++++++++++
 tb/tb_vector_exec_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared definitions for the vector execution unit: op encodings, FSM states
// and the beat-count helper used to size the EXEC phase.
package vector_pkg;

  localparam logic [2:0] VOP_ADD  = 3'b000;
  localparam logic [2:0] VOP_SUB  = 3'b001;
  localparam logic [2:0] VOP_AND  = 3'b010;
  localparam logic [2:0] VOP_OR   = 3'b011;
  localparam logic [2:0] VOP_XOR  = 3'b100;
  localparam logic [2:0] VOP_MOVI = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } vstate_t;

  // Number of EXEC beats needed to cover vlen elements with lanes elements per beat.
  function automatic int nbeats(input int vlen, input int lanes);
    return (vlen + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/vector_exec_unit_lane.sv
// One-element combinational vector ALU. Reserved op codes produce 0, which makes
// them behave as MOVI of zero. Optional macro VECTOR_SAT_EN turns ADD/SUB into
// signed saturating operations and raises sat when the result is clamped.
module vector_lane
  import vector_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] y,
  output logic             sat
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sum  = a + s;
  assign diff = a - s;

  // Select the element result; overflow clamps toward the sign of a when saturation is built in.
  always_comb begin
    y   = '0;
    sat = 1'b0;
    case (op)
      VOP_ADD: begin
        y = sum;
`ifdef VECTOR_SAT_EN
        if ((a[WIDTH-1] == s[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1])) begin
          sat = 1'b1;
          y   = a[WIDTH-1] ? SMIN : SMAX;
        end
`endif
      end
      VOP_SUB: begin
        y = diff;
`ifdef VECTOR_SAT_EN
        if ((a[WIDTH-1] != s[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1])) begin
          sat = 1'b1;
          y   = a[WIDTH-1] ? SMIN : SMAX;
        end
`endif
      end
      VOP_AND:  y = a & s;
      VOP_OR:   y = a | s;
      VOP_XOR:  y = a ^ s;
      VOP_MOVI: y = s;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/vector_exec_unit.sv
// Multi-cycle vector execution unit: NVREG x VLEN register file plus LANES
// element ALUs stepping through a vector in NBEATS beats. One op at a time is
// issued through start/busy/done. Optional macro VECTOR_SAT_EN selects signed
// saturating ADD/SUB (otherwise wrap-around, satflag stays 0).
module vector_exec_unit
  import vector_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int VLEN  = 5,
  parameter  int NVREG = 16,
  parameter  int LANES = 1,
  localparam int AW    = (NVREG > 1) ? $clog2(NVREG) : 1,
  localparam int EW    = (VLEN > 1) ? $clog2(VLEN) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    va,
  input  logic [AW-1:0]    vd,
  input  logic [WIDTH-1:0] scalar,
  output logic             busy,
  output logic             done,
  output logic             zflag,
  output logic             satflag,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_vreg,
  input  logic [EW-1:0]    ld_elem,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [AW-1:0]    rd_vreg,
  input  logic [EW-1:0]    rd_elem,
  output logic [WIDTH-1:0] rd_data
);

  localparam int NBEATS = nbeats(VLEN, LANES);
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  vstate_t          state, state_next;
  logic [2:0]       op_q;
  logic [AW-1:0]    va_q, vd_q;
  logic [WIDTH-1:0] scalar_q;
  logic [BW-1:0]    beat;
  logic             z_acc, sat_acc;
  logic             accept, last_beat;
  logic             beat_nonzero, beat_sat;

  logic [WIDTH-1:0] vregs  [NVREG][VLEN];
  logic [WIDTH-1:0] lane_a [LANES];
  logic [WIDTH-1:0] lane_y [LANES];
  logic [EW-1:0]    lane_elem [LANES];
  logic [LANES-1:0] lane_valid;
  logic [LANES-1:0] lane_sat;

  assign busy      = (state != S_IDLE);
  assign accept    = start && (state == S_IDLE);
  assign last_beat = (beat == BW'(NBEATS - 1));

  // Each lane handles element beat*LANES+l; lanes past the vector end are masked.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [31:0] idx;
    assign idx           = 32'(beat) * 32'(LANES) + 32'(l);
    assign lane_valid[l] = (idx < 32'(VLEN));
    assign lane_elem[l]  = idx[EW-1:0];
    assign lane_a[l]     = lane_valid[l] ? vregs[va_q][lane_elem[l]] : '0;

    vector_lane #(.WIDTH(WIDTH)) u_lane (
      .op  (op_q),
      .a   (lane_a[l]),
      .s   (scalar_q),
      .y   (lane_y[l]),
      .sat (lane_sat[l])
    );
  end

  // Next-state logic: accept only from IDLE, leave EXEC after the final beat, DONE lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_EXEC;
      S_EXEC:  if (last_beat) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Summarise the written lanes of the current beat for the zero and saturation flags.
  always_comb begin
    beat_nonzero = 1'b0;
    beat_sat     = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_valid[l]) begin
        if (lane_y[l] != '0) beat_nonzero = 1'b1;
        if (lane_sat[l])     beat_sat     = 1'b1;
      end
    end
  end

  // State register, operand latches, beat counter and the done/flag outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= '0;
      va_q     <= '0;
      vd_q     <= '0;
      scalar_q <= '0;
      beat     <= '0;
      z_acc    <= 1'b0;
      sat_acc  <= 1'b0;
      done     <= 1'b0;
      zflag    <= 1'b0;
      satflag  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == S_DONE);
      if (accept) begin
        op_q     <= op;
        va_q     <= va;
        vd_q     <= vd;
        scalar_q <= scalar;
        beat     <= '0;
        z_acc    <= 1'b1;
        sat_acc  <= 1'b0;
        satflag  <= 1'b0;
      end else if (state == S_EXEC) begin
        beat <= beat + BW'(1);
        if (beat_nonzero) z_acc   <= 1'b0;
        if (beat_sat)     sat_acc <= 1'b1;
      end
      if (state == S_DONE) begin
        zflag   <= z_acc;
        satflag <= sat_acc;
      end
    end
  end

  // Register file with host load port, EXEC write-back and a read-before-write registered read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < NVREG; v++) begin
        for (int e = 0; e < VLEN; e++) begin
          vregs[v][e] <= '0;
        end
      end
      rd_data <= '0;
    end else begin
      rd_data <= (32'(rd_elem) < 32'(VLEN)) ? vregs[rd_vreg][rd_elem] : '0;
      if (ld_en && !busy && (32'(ld_elem) < 32'(VLEN))) begin
        vregs[ld_vreg][ld_elem] <= ld_data;
      end
      if (state == S_EXEC) begin
        for (int l = 0; l < LANES; l++) begin
          if (lane_valid[l]) vregs[vd_q][lane_elem[l]] <= lane_y[l];
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_exec_unit.sv
// Directed bench for vector_exec_unit: one single-lane and one dual-lane instance
// share the same stimulus; read-back expectations go through a scoreboard queue.
module tb_vector_exec_unit;
  import vector_pkg::*;

  localparam int WIDTH = 32;
  localparam int VLEN  = 5;
  localparam int AW    = 4;
  localparam int EW    = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [2:0]       op;
  logic [AW-1:0]    va, vd;
  logic [WIDTH-1:0] scalar;
  logic             ld_en;
  logic [AW-1:0]    ld_vreg;
  logic [EW-1:0]    ld_elem;
  logic [WIDTH-1:0] ld_data;
  logic [AW-1:0]    rd_vreg;
  logic [EW-1:0]    rd_elem;

  logic             busy_1, done_1, zflag_1, satflag_1;
  logic [WIDTH-1:0] rd_data_1;
  logic             busy_2, done_2, zflag_2, satflag_2;
  logic [WIDTH-1:0] rd_data_2;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] sb_q[$];
  string            tag_q[$];
  logic [WIDTH-1:0] vec [VLEN];
  int done_cycle_1, done_cycle_2, done_count_1, done_count_2;

  always #5 clk = ~clk;

  vector_exec_unit #(.WIDTH(WIDTH), .VLEN(VLEN), .NVREG(16), .LANES(1)) dut_1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .va(va), .vd(vd), .scalar(scalar),
    .busy(busy_1), .done(done_1), .zflag(zflag_1), .satflag(satflag_1),
    .ld_en(ld_en), .ld_vreg(ld_vreg), .ld_elem(ld_elem), .ld_data(ld_data),
    .rd_vreg(rd_vreg), .rd_elem(rd_elem), .rd_data(rd_data_1)
  );

  vector_exec_unit #(.WIDTH(WIDTH), .VLEN(VLEN), .NVREG(16), .LANES(2)) dut_2 (
    .clk(clk), .reset(reset), .start(start), .op(op), .va(va), .vd(vd), .scalar(scalar),
    .busy(busy_2), .done(done_2), .zflag(zflag_2), .satflag(satflag_2),
    .ld_en(ld_en), .ld_vreg(ld_vreg), .ld_elem(ld_elem), .ld_data(ld_data),
    .rd_vreg(rd_vreg), .rd_elem(rd_elem), .rd_data(rd_data_2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic [AW-1:0] a,
                               input logic [AW-1:0] d, input logic [WIDTH-1:0] s);
    start = 1'b1; op = o; va = a; vd = d; scalar = s;
    tick();
    start = 1'b0;
  endtask

  task automatic loadElem(input logic [AW-1:0] v, input logic [EW-1:0] e,
                          input logic [WIDTH-1:0] d);
    ld_en = 1'b1; ld_vreg = v; ld_elem = e; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic loadVec(input logic [AW-1:0] v);
    for (int e = 0; e < VLEN; e++) loadElem(v, EW'(e), vec[e]);
  endtask

  task automatic readElem(input logic [AW-1:0] v, input logic [EW-1:0] e,
                          input logic [WIDTH-1:0] expected, input string tag);
    logic [WIDTH-1:0] exp_v;
    string            t;
    sb_q.push_back(expected);
    tag_q.push_back(tag);
    rd_vreg = v; rd_elem = e;
    tick();
    exp_v = sb_q.pop_front();
    t     = tag_q.pop_front();
    checkOutput({t, "_L1"}, rd_data_1, exp_v);
    checkOutput({t, "_L2"}, rd_data_2, exp_v);
  endtask

  task automatic readVec(input logic [AW-1:0] v, input string tag);
    for (int e = 0; e < VLEN; e++) readElem(v, EW'(e), vec[e], $sformatf("%s_e%0d", tag, e));
  endtask

  // Watch a fixed window after accept; mode 1 pulses a stray start, mode 2 a stray load.
  task automatic runOp(input int mode);
    done_cycle_1 = 0; done_cycle_2 = 0; done_count_1 = 0; done_count_2 = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 2 && mode == 1) begin
        start = 1'b1; op = VOP_MOVI; va = 4'd1; vd = 4'd6; scalar = 32'h99;
      end
      if (c == 2 && mode == 2) begin
        ld_en = 1'b1; ld_vreg = 4'd1; ld_elem = 3'd0; ld_data = 32'h1234;
      end
      tick();
      start = 1'b0;
      ld_en = 1'b0;
      if (done_1) begin
        done_count_1++;
        if (done_cycle_1 == 0) done_cycle_1 = c;
      end
      if (done_2) begin
        done_count_2++;
        if (done_cycle_2 == 0) done_cycle_2 = c;
      end
    end
  endtask

  task automatic checkDone(input string tag, input logic zexp);
    checkOutput({tag, "_latency_L1"}, done_cycle_1, 6);
    checkOutput({tag, "_latency_L2"}, done_cycle_2, 4);
    checkOutput({tag, "_dones_L1"}, done_count_1, 1);
    checkOutput({tag, "_dones_L2"}, done_count_2, 1);
    checkOutput({tag, "_zflag_L1"}, zflag_1, zexp);
    checkOutput({tag, "_zflag_L2"}, zflag_2, zexp);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; va = '0; vd = '0; scalar = '0;
    ld_en = 1'b0; ld_vreg = '0; ld_elem = '0; ld_data = '0; rd_vreg = '0; rd_elem = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checkOutput("rst_busy_L1", busy_1, 0);
    checkOutput("rst_busy_L2", busy_2, 0);
    checkOutput("rst_done_L1", done_1, 0);
    checkOutput("rst_done_L2", done_2, 0);
    checkOutput("rst_zflag_L1", zflag_1, 0);
    checkOutput("rst_satflag_L1", satflag_1, 0);
    checkOutput("rst_rd_L1", rd_data_1, 0);
    checkOutput("rst_rd_L2", rd_data_2, 0);

    $display("[TB] ADD v2=v1+10");
    vec = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    loadVec(4'd1);
    applyStimulus(VOP_ADD, 4'd1, 4'd2, 32'd10);
    runOp(0);
    checkDone("t1", 1'b0);
    checkOutput("t1_busy_L1", busy_1, 0);
    vec = '{32'd11, 32'd12, 32'd13, 32'd14, 32'd15};
    readVec(4'd2, "t1_v2");

    $display("[TB] SUB v3=v1-1 with partial last beat");
    vec = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    loadVec(4'd1);
    loadElem(4'd4, 3'd0, 32'h55);
    applyStimulus(VOP_SUB, 4'd1, 4'd3, 32'd1);
    runOp(0);
    checkDone("t2", 1'b1);
    vec = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    readVec(4'd3, "t2_v3");
    readElem(4'd4, 3'd0, 32'h55, "t2_v4_untouched");
    readElem(4'd2, 3'd6, 32'd0, "t2_rd_oob");

    $display("[TB] start while busy is ignored");
    applyStimulus(VOP_ADD, 4'd1, 4'd5, 32'd7);
    runOp(1);
    checkDone("t3", 1'b0);
    vec = '{32'd8, 32'd8, 32'd8, 32'd8, 32'd8};
    readVec(4'd5, "t3_v5");
    vec = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    readVec(4'd6, "t3_v6");

    $display("[TB] in-place XOR, load during busy dropped");
    vec = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    loadVec(4'd1);
    applyStimulus(VOP_XOR, 4'd1, 4'd1, 32'hFFFF_FFFF);
    runOp(2);
    checkDone("t4", 1'b0);
    vec = '{32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'hFFFF_FFFA};
    readVec(4'd1, "t4_v1");

    $display("[TB] AND, OR, reserved, MOVI");
    applyStimulus(VOP_AND, 4'd1, 4'd7, 32'hFF);
    runOp(0);
    checkDone("and", 1'b0);
    vec = '{32'hFE, 32'hFD, 32'hFC, 32'hFB, 32'hFA};
    readVec(4'd7, "and_v7");
    applyStimulus(VOP_OR, 4'd2, 4'd8, 32'h100);
    runOp(0);
    checkDone("or", 1'b0);
    vec = '{32'h10B, 32'h10C, 32'h10D, 32'h10E, 32'h10F};
    readVec(4'd8, "or_v8");
    applyStimulus(3'b110, 4'd2, 4'd9, 32'h55);
    runOp(0);
    checkDone("rsv", 1'b1);
    vec = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    readVec(4'd9, "rsv_v9");
    applyStimulus(VOP_MOVI, 4'd2, 4'd10, 32'hABCD);
    runOp(0);
    checkDone("movi", 1'b0);
    vec = '{32'hABCD, 32'hABCD, 32'hABCD, 32'hABCD, 32'hABCD};
    readVec(4'd10, "movi_v10");

    $display("[TB] signed overflow behaviour");
    vec = '{32'h7FFF_FFF0, 32'd1, 32'd2, 32'd3, 32'd4};
    loadVec(4'd12);
    applyStimulus(VOP_ADD, 4'd12, 4'd11, 32'h20);
    runOp(0);
    checkDone("sat_add", 1'b0);
`ifdef VECTOR_SAT_EN
    vec = '{32'h7FFF_FFFF, 32'h21, 32'h22, 32'h23, 32'h24};
    checkOutput("sat_add_flag_L1", satflag_1, 1);
    checkOutput("sat_add_flag_L2", satflag_2, 1);
`else
    vec = '{32'h8000_0010, 32'h21, 32'h22, 32'h23, 32'h24};
    checkOutput("sat_add_flag_L1", satflag_1, 0);
    checkOutput("sat_add_flag_L2", satflag_2, 0);
`endif
    readVec(4'd11, "sat_add_v11");
    vec = '{32'h8000_0005, 32'd0, 32'd0, 32'd0, 32'd0};
    loadVec(4'd12);
    applyStimulus(VOP_SUB, 4'd12, 4'd11, 32'h10);
    runOp(0);
    checkDone("sat_sub", 1'b0);
`ifdef VECTOR_SAT_EN
    vec = '{32'h8000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
    checkOutput("sat_sub_flag_L1", satflag_1, 1);
`else
    vec = '{32'h7FFF_FFF5, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
    checkOutput("sat_sub_flag_L1", satflag_1, 0);
`endif
    readVec(4'd11, "sat_sub_v11");
    applyStimulus(VOP_ADD, 4'd1, 4'd13, 32'd1);
    runOp(0);
    checkOutput("sat_clear_L1", satflag_1, 0);
    checkOutput("sat_clear_L2", satflag_2, 0);

    $display("[TB] read-before-write on the same element");
    sb_q.push_back(32'd0);
    tag_q.push_back("rbw_old");
    rd_vreg = 4'd14; rd_elem = 3'd0;
    ld_en = 1'b1; ld_vreg = 4'd14; ld_elem = 3'd0; ld_data = 32'h77;
    tick();
    ld_en = 1'b0;
    begin
      logic [WIDTH-1:0] exp_v;
      string            t;
      exp_v = sb_q.pop_front();
      t     = tag_q.pop_front();
      checkOutput({t, "_L1"}, rd_data_1, exp_v);
      checkOutput({t, "_L2"}, rd_data_2, exp_v);
    end
    readElem(4'd14, 3'd0, 32'h77, "rbw_new");

    $display("[TB] reset during second EXEC beat");
    applyStimulus(VOP_ADD, 4'd1, 4'd13, 32'd1);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("t5_busy_L1", busy_1, 0);
    checkOutput("t5_busy_L2", busy_2, 0);
    tick();
    reset = 1'b0;
    runOp(0);
    checkOutput("t5_dones_L1", done_count_1, 0);
    checkOutput("t5_dones_L2", done_count_2, 0);
    vec = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    readVec(4'd1, "t5_v1");
    readVec(4'd13, "t5_v13");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
